// File: rtl/transpose_sequencer_if.sv
// Signal bundle between the transpose job sequencer, its command/word source and data_transposer.
// The slave modport is the sequencer's view. The master modport is the environment's view.
interface transpose_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_prec;
  logic [31:0]      cmd_baddr;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_data;
  logic [31:0]      tp_prec;
  logic [31:0]      tp_baddr;
  logic             tp_start;
  logic [XLEN-1:0]  tp_iword;
  logic             tp_iword_vld;
  logic             tp_busy;
  logic             tp_wr_en;
  logic             active;
  logic [CNT_W-1:0] words_left;
  logic             done;
  logic             aborted;
  logic             cmd_err;

  modport slave (
    input  cmd_valid, cmd_prec, cmd_baddr, cmd_len, abort,
           in_valid, in_data, tp_busy, tp_wr_en,
    output cmd_ready, in_ready, tp_prec, tp_baddr, tp_start, tp_iword,
           tp_iword_vld, active, words_left, done, aborted, cmd_err
  );

  modport master (
    output cmd_valid, cmd_prec, cmd_baddr, cmd_len, abort,
           in_valid, in_data, tp_busy, tp_wr_en,
    input  cmd_ready, in_ready, tp_prec, tp_baddr, tp_start, tp_iword,
           tp_iword_vld, active, words_left, done, aborted, cmd_err
  );
endinterface

// File: rtl/transpose_sequencer.sv
// Job-level controller for data_transposer: accepts one job, feeds its words whenever the
// transposer is idle, waits for the MVU writes to drain, then reports done.
module transpose_sequencer #(
  parameter int XLEN          = 32,
  parameter int MAX_DATA_PREC = 16,
  parameter int CNT_W         = 16,
  parameter int DRAIN_IDLE    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  transpose_sequencer_if.slave  bus
);

  localparam int IDLE_W = $clog2(DRAIN_IDLE + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_IDLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_prec;
  logic [31:0]       r_baddr;
  logic [CNT_W-1:0]  r_words_left;
  logic [CNT_W-1:0]  w_words_left_nxt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_cnt_nxt;
  logic              r_tp_start;
  logic              r_done;
  logic              r_aborted;
  logic              r_cmd_err;
  logic              w_done_nxt;
  logic              w_aborted_nxt;
  logic              w_cmd_err_nxt;
  logic              w_latch;
  logic              w_in_ready;
  logic              w_hs;
  logic              w_tp_idle;
  logic              w_cmd_legal;
  logic [XLEN-1:0]   w_iword;

  assign w_tp_idle   = !bus.tp_busy && !bus.tp_wr_en;
  assign w_cmd_legal = (bus.cmd_prec != 32'd0) &&
                       (bus.cmd_prec <= 32'(MAX_DATA_PREC)) &&
                       (bus.cmd_len != '0);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_words_left_nxt = r_words_left;
    w_idle_cnt_nxt   = r_idle_cnt;
    w_done_nxt       = 1'b0;
    w_aborted_nxt    = 1'b0;
    w_cmd_err_nxt    = 1'b0;
    w_latch          = 1'b0;
    w_in_ready       = 1'b0;
    w_hs             = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_idle_cnt_nxt = '0;
        if (bus.cmd_valid) begin
          if (w_cmd_legal) begin
            w_latch          = 1'b1;
            w_words_left_nxt = bus.cmd_len;
            w_next_state     = ST_FEED;
          end else begin
            w_cmd_err_nxt = 1'b1;
          end
        end
      end

      ST_FEED: begin
        // Abort suppresses the handshake, so a word is never half-delivered.
        w_in_ready = w_tp_idle && !bus.abort && (r_words_left != '0);
        w_hs       = bus.in_valid && w_in_ready;
        if (bus.abort) begin
          w_next_state     = ST_IDLE;
          w_aborted_nxt    = 1'b1;
          w_words_left_nxt = '0;
        end else if (w_hs) begin
          w_words_left_nxt = r_words_left - CNT_W'(1);
          if (r_words_left == CNT_W'(1)) begin
            w_next_state   = ST_DRAIN;
            w_idle_cnt_nxt = '0;
          end
        end
      end

      ST_DRAIN: begin
        if (bus.abort) begin
          w_next_state     = ST_IDLE;
          w_aborted_nxt    = 1'b1;
          w_words_left_nxt = '0;
          w_idle_cnt_nxt   = '0;
        end else if (!w_tp_idle) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_next_state   = ST_IDLE;
          w_done_nxt     = 1'b1;
          w_idle_cnt_nxt = '0;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_prec       <= '0;
      r_baddr      <= '0;
      r_words_left <= '0;
      r_idle_cnt   <= '0;
      r_tp_start   <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_words_left <= w_words_left_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_tp_start   <= (w_next_state != ST_IDLE);
      r_done       <= w_done_nxt;
      r_aborted    <= w_aborted_nxt;
      r_cmd_err    <= w_cmd_err_nxt;
      if (w_latch) begin
        r_prec  <= bus.cmd_prec;
        r_baddr <= bus.cmd_baddr;
      end
    end
  end

  assign w_iword = w_hs ? bus.in_data : '0;

  assign bus.cmd_ready    = (r_state == ST_IDLE);
  assign bus.in_ready     = w_in_ready;
  assign bus.tp_prec      = r_prec;
  assign bus.tp_baddr     = r_baddr;
  assign bus.tp_start     = r_tp_start;
  assign bus.tp_iword     = w_iword;
  assign bus.tp_iword_vld = w_hs;
  assign bus.active       = (r_state != ST_IDLE);
  assign bus.words_left   = r_words_left;
  assign bus.done         = r_done;
  assign bus.aborted      = r_aborted;
  assign bus.cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_transpose_sequencer.sv
// Directed bench for transpose_sequencer: legal/stalled/illegal/aborted jobs and reset during drain.
module tb_transpose_sequencer;
  localparam int XLEN       = 32;
  localparam int CNT_W      = 16;
  localparam int MAX_PREC   = 16;
  localparam int DRAIN_IDLE = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_prec;
  logic [31:0] last_baddr;

  transpose_sequencer_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  transpose_sequencer #(
    .XLEN(XLEN), .MAX_DATA_PREC(MAX_PREC), .CNT_W(CNT_W), .DRAIN_IDLE(DRAIN_IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int job, input int k);
    return (32'(job) << 24) | 32'h005A_0000 | 32'(k);
  endfunction

  task automatic check_reset_state(input string pfx);
    check({pfx, "_cmd_ready"},  64'(bus.cmd_ready),    64'd1);
    check({pfx, "_tp_start"},   64'(bus.tp_start),     64'd0);
    check({pfx, "_active"},     64'(bus.active),       64'd0);
    check({pfx, "_words_left"}, 64'(bus.words_left),   64'd0);
    check({pfx, "_tp_prec"},    64'(bus.tp_prec),      64'd0);
    check({pfx, "_tp_baddr"},   64'(bus.tp_baddr),     64'd0);
    check({pfx, "_pulses"},     64'({bus.done, bus.aborted, bus.cmd_err}), 64'd0);
    check({pfx, "_in_ready"},   64'(bus.in_ready),     64'd0);
    check({pfx, "_iword_vld"},  64'(bus.tp_iword_vld), 64'd0);
  endtask

  // Presents one command for a single cycle; returns at +1 in the cycle after the accept edge.
  task automatic send_cmd(input string tag, input logic [31:0] prec, input logic [31:0] baddr,
                          input int len, input bit legal);
    bus.cmd_valid = 1'b1;
    bus.cmd_prec  = prec;
    bus.cmd_baddr = baddr;
    bus.cmd_len   = CNT_W'(len);
    #4;
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
    if (legal) begin
      last_prec  = prec;
      last_baddr = baddr;
      check({tag, "_tp_start"},   64'(bus.tp_start),   64'd1);
      check({tag, "_active"},     64'(bus.active),     64'd1);
      check({tag, "_words_left"}, 64'(bus.words_left), 64'(len));
      check({tag, "_tp_prec"},    64'(bus.tp_prec),    64'(prec));
      check({tag, "_tp_baddr"},   64'(bus.tp_baddr),   64'(baddr));
      check({tag, "_busy_ready"}, 64'(bus.cmd_ready),  64'd0);
    end else begin
      check({tag, "_cmd_err"},  64'(bus.cmd_err),  64'd1);
      check({tag, "_tp_start"}, 64'(bus.tp_start), 64'd0);
      check({tag, "_idle"},     64'({bus.active, bus.cmd_ready}), 64'b01);
      check({tag, "_prec_kept"},  64'(bus.tp_prec),  64'(last_prec));
      check({tag, "_baddr_kept"}, 64'(bus.tp_baddr), 64'(last_baddr));
      tick();
      check({tag, "_cmd_err_1cyc"}, 64'(bus.cmd_err), 64'd0);
    end
  endtask

  // Source always valid. A stall window of 10 cycles follows every busy_every-th word:
  // tp_busy in window cycles 1..8, tp_wr_en in cycles 7..10. abort is raised once abort_k
  // words have been taken. Cycle c is the c-th cycle after the accept edge. Returns at +5
  // in the cycle where done or aborted is seen.
  task automatic run_feed(input int job, input int len, input int busy_every, input int abort_k,
                          output int words, output int first_at, output int done_at,
                          output int abort_at);
    int busy_left = 0;
    int pos;
    int ready_bad = 0;
    int vld_bad   = 0;
    int data_bad  = 0;
    bit stall;
    words = 0; first_at = -1; done_at = -1; abort_at = -1;
    for (int c = 1; c <= 400; c++) begin
      stall = (busy_left > 0);
      pos   = 11 - busy_left;
      bus.tp_busy  = stall && (pos <= 8);
      bus.tp_wr_en = stall && (pos >= 7);
      if (stall) busy_left--;
      bus.in_valid = 1'b1;
      bus.in_data  = word_of(job, words);
      bus.abort    = (abort_k >= 0) && (words == abort_k);
      #4;
      if (bus.done === 1'b1) begin done_at = c; break; end
      if (bus.aborted === 1'b1) begin abort_at = c; break; end
      if (bus.in_ready !== ((words < len) && !stall && !bus.abort)) ready_bad++;
      if (bus.tp_iword_vld !== bus.in_ready) vld_bad++;
      if (bus.tp_iword_vld === 1'b1) begin
        if (bus.tp_iword !== word_of(job, words)) data_bad++;
        if (first_at < 0) first_at = c;
        words++;
        if (busy_every > 0 && (words % busy_every) == 0) busy_left = 10;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    bus.tp_busy  = 1'b0;
    bus.tp_wr_en = 1'b0;
    check($sformatf("job%0d_in_ready_bad", job), 64'(ready_bad), 64'd0);
    check($sformatf("job%0d_vld_bad", job),      64'(vld_bad),   64'd0);
    check($sformatf("job%0d_data_bad", job),     64'(data_bad),  64'd0);
  endtask

  initial begin
    int words, first_at, done_at, abort_at, stray;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_prec = '0; bus.cmd_baddr = '0; bus.cmd_len = '0;
    bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.tp_busy = 1'b0; bus.tp_wr_en = 1'b0;
    last_prec = '0; last_baddr = '0;
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // Job 1: len 64, no stalls: done 64+2+1 cycles after accept.
    send_cmd("job1", 32'd8, 32'h0000_0000, 64, 1'b1);
    run_feed(1, 64, 0, -1, words, first_at, done_at, abort_at);
    check("job1_words",    64'(words),    64'd64);
    check("job1_first_at", 64'(first_at), 64'd1);
    check("job1_done_at",  64'(done_at),  64'd67);
    check("job1_done_cycle_state", 64'({bus.tp_start, bus.active, bus.cmd_ready}), 64'b001);
    tick();
    check("job1_done_1cyc", 64'(bus.done), 64'd0);

    // Job 2: stalls after every 8th word; last stall ends at c=144, so done at c=147.
    send_cmd("job2", 32'd8, 32'h0000_0200, 64, 1'b1);
    run_feed(2, 64, 8, -1, words, first_at, done_at, abort_at);
    check("job2_words",   64'(words),   64'd64);
    check("job2_done_at", 64'(done_at), 64'd147);
    check("job2_no_abort", 64'(abort_at), 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    // Illegal commands leave the block idle with the previous job's values.
    send_cmd("bad_prec0",  32'd0,  32'h0000_0AAA, 5, 1'b0);
    send_cmd("bad_prec17", 32'd17, 32'h0000_0BBB, 5, 1'b0);
    send_cmd("bad_len0",   32'd4,  32'h0000_0CCC, 0, 1'b0);

    // Job 3: abort once 20 words are taken (raised in c=21, aborted seen in c=22).
    send_cmd("job3", 32'd12, 32'h0000_0300, 64, 1'b1);
    run_feed(3, 64, 0, 20, words, first_at, done_at, abort_at);
    check("job3_words",    64'(words),    64'd20);
    check("job3_abort_at", 64'(abort_at), 64'd22);
    check("job3_abort_state", 64'({bus.tp_start, bus.active, bus.done}), 64'd0);
    check("job3_words_left",  64'(bus.words_left), 64'd0);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.aborted !== 1'b0) stray++;
    end
    check("job3_no_late_pulse", 64'(stray), 64'd0);

    // Job 4: a normal job after the abort, prec at the legal maximum.
    send_cmd("job4", 32'd16, 32'h0000_0400, 5, 1'b1);
    run_feed(4, 5, 0, -1, words, first_at, done_at, abort_at);
    check("job4_words",   64'(words),   64'd5);
    check("job4_done_at", 64'(done_at), 64'd8);
    tick();

    // Job 5: abort coincides with the would-be final handshake.
    send_cmd("job5", 32'd1, 32'h0000_0500, 4, 1'b1);
    run_feed(5, 4, 0, 3, words, first_at, done_at, abort_at);
    check("job5_words",    64'(words),    64'd3);
    check("job5_abort_at", 64'(abort_at), 64'd5);
    check("job5_no_done",  64'(done_at),  64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("job5_aborted_1cyc", 64'(bus.aborted), 64'd0);

    // Job 6: reset while draining.
    send_cmd("job6", 32'd4, 32'h0000_0600, 2, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = word_of(6, 0);
    tick();
    bus.in_data  = word_of(6, 1);
    tick();
    bus.in_valid = 1'b0;
    #4;
    check("job6_drain_state", 64'({bus.active, bus.in_ready, bus.tp_start}), 64'b101);
    check("job6_drain_left",  64'(bus.words_left), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("job6_rst");
    rst = 1'b0;
    tick();
    check("job6_no_pulse", 64'({bus.done, bus.aborted, bus.cmd_err}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/transpose_sequencer.md
# transpose_sequencer

Job-level controller for `data_transposer`. It accepts one transpose job at a time: base address, precision and input word count. It pulls the job's XLEN-bit words from a valid/ready source stream and presents them to the transposer only in cycles where the transposer can take them (`busy` and `mvu_wr_en` both low). After the last word it waits for the transposer to drain its MVU writes, then signals completion. It sits between the host/DMA word source and `data_transposer`, replacing the bench-style feeding loop with synthesizable sequencing.

## Interface
Parameters:
- `XLEN`, 32, input word width
- `MAX_DATA_PREC`, 16, largest legal precision
- `CNT_W`, 16, width of the job word count
- `DRAIN_IDLE`, 2, consecutive idle transposer cycles required before done (≥1)

Ports:
- `clk` in 1 — single clock; all logic on rising edge
- `rst` in 1 — reset; synchronous, active-high
- `cmd_valid` in 1 — job command valid
- `cmd_ready` out 1 — high only in IDLE
- `cmd_prec` in 32 — precision, legal 1..MAX_DATA_PREC
- `cmd_baddr` in 32 — MVU base address for the job
- `cmd_len` in CNT_W — number of input words, legal ≥1
- `abort` in 1 — cancel current job
- `in_valid` in 1 — source word valid
- `in_ready` out 1 — source word accepted this cycle when high with in_valid
- `in_data` in XLEN — source word
- `tp_prec` out 32 — to transposer `prec` (latched job value)
- `tp_baddr` out 32 — to transposer `baddr` (latched job value)
- `tp_start` out 1 — to transposer `start`
- `tp_iword` out XLEN — to transposer `iword`
- `tp_iword_vld` out 1 — qualifies tp_iword
- `tp_busy` in 1 — from transposer `busy`
- `tp_wr_en` in 1 — from transposer `mvu_wr_en`
- `active` out 1 — high in FEED or DRAIN
- `words_left` out CNT_W — words still to be accepted in current job
- `done` out 1 — one-cycle pulse, job completed
- `aborted` out 1 — one-cycle pulse, job cancelled
- `cmd_err` out 1 — one-cycle pulse, illegal command rejected

## Operation
- States: IDLE, FEED, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` with legal parameters: latch prec, baddr and len into `words_left`; go to FEED.
  - On `cmd_valid` with illegal parameters (`cmd_prec`==0, `cmd_prec`>MAX_DATA_PREC, or `cmd_len`==0): command is consumed, `cmd_err` pulses next cycle, state stays IDLE and latched values are unchanged.
- FEED:
  - `in_ready` = !tp_busy && !tp_wr_en && !abort && words_left≠0. This is combinational.
  - Handshake (`in_valid`&&`in_ready`): `tp_iword`=`in_data` and `tp_iword_vld`=1 in the same cycle, combinational passthrough. Otherwise `tp_iword`=0 and `tp_iword_vld`=0.
  - Each handshake decrements `words_left`. The handshake that takes it 1→0 moves the state to DRAIN.
- DRAIN:
  - `in_ready`=0.
  - An idle counter increments on each cycle with !tp_busy && !tp_wr_en, and clears to 0 on any cycle where either is high.
  - When the counter reaches DRAIN_IDLE: go to IDLE and pulse `done`.
- `tp_start`: registered; 1 in FEED and DRAIN, 0 in IDLE. `tp_prec` and `tp_baddr` hold the latched values at all times.
- `abort` in FEED or DRAIN: go to IDLE next cycle, pulse `aborted`, no `done`, `words_left` cleared. `abort` in IDLE is ignored.
- `abort` in the same cycle as a would-be final handshake: abort wins and no word is transferred.
- Source data is never dropped or duplicated. Words beyond `cmd_len` are left in the source.

## Timing
- Reset values: all outputs 0 except `cmd_ready`=1 (IDLE); `tp_prec`=0 and `tp_baddr`=0.
- `rst` mid-job: next cycle is IDLE, `tp_start`=0, no `done`/`aborted` pulse.
- Command accepted at edge N: `tp_start`=1, `active`=1 and `words_left`=len from cycle N+1. The first handshake is possible in cycle N+1.
- Word path latency: 0 cycles from handshake to `tp_iword_vld`.
- Throughput: 1 word/cycle while transposer is idle and the source is valid.
- `done`/`aborted`/`cmd_err` are registered, high exactly one cycle.
- Minimum job length in cycles, no stalls: len + DRAIN_IDLE + 1 from accept to `done`.
- `tp_busy` rising in the same cycle as `in_valid`: `in_ready`=0 that cycle and no word is issued.

## Test plan
- Legal job, prec=8, baddr=0, len=64, source always valid, transposer never busy → 64 consecutive `tp_iword_vld` cycles, data in order, `done` at cycle 64+2+1 after accept, `tp_start` drops the same edge.
- Same job, tp_busy asserted for 10 cycles after every 8th word → no `tp_iword_vld` during busy or tp_wr_en cycles, all 64 words delivered once, `done` only after 2 idle cycles following the last busy.
- Illegal commands prec=0, prec=17, len=0 → `cmd_err` pulse each, state stays IDLE, `tp_start` stays 0.
- Abort after 20 words of len=64 → `aborted` pulse, `words_left`=0, `tp_start`=0 next cycle, no `done`; the next job then runs normally.
- Abort coinciding with the final handshake (len=4, abort on 4th valid) → only 3 words issued, `aborted` pulse, no `done`.
- `rst` asserted in DRAIN → all outputs at reset values next cycle, no pulses.
